pio_irq_servicer: RTL and testbench

//  Avalon-MM master that services a PIO edge-capture slave (input PIO with IRQ mask, edge capture).
//  On reset exit it programs the slave IRQ mask. On each irq it reads edge capture, clears it, and

---
 rtl/pio_svc_pkg.sv | 23 ++
 rtl/pio_irq_servicer.sv | 158 +++++++++++++++
 tb/tb_pio_irq_servicer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_svc_pkg.sv
// Shared definitions for the PIO edge-capture servicer.
// Holds the PIO slave register map (word addresses) and the servicer FSM
// state encoding.
package pio_svc_pkg;

  // PIO slave word addresses
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  typedef enum logic [3:0] {
    S_INIT_MASK = 4'd0,
    S_IDLE      = 4'd1,
    S_SET_MASK  = 4'd2,
    S_RD_CAP    = 4'd3,
    S_WAIT_CAP  = 4'd4,
    S_WR_CLR    = 4'd5,
    S_RD_DATA   = 4'd6,
    S_WAIT_DATA = 4'd7,
    S_PUSH      = 4'd8
  } state_t;

endpackage

// File: rtl/pio_irq_servicer.sv
// Avalon-MM master that services a PIO edge-capture slave.
// After reset it programs the slave IRQ mask. On each irq it reads the
// edge-capture register, clears the captured bits, reads the pin levels and
// offers {edges,data} as one event on a valid/ready stream.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   avm_*                 Avalon-MM master (registered commands, one read in flight)
//   irq                   level interrupt from the PIO slave
//   cfg_mask/cfg_mask_wr  request to reprogram the slave IRQ mask
//   evt_valid/evt_ready   event handshake; evt_edges/evt_data carry the event
//   busy                  FSM is not in IDLE
module pio_irq_servicer
  import pio_svc_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter logic [WIDTH-1:0] MASK_INIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_readdatavalid,
  input  logic             avm_waitrequest,
  input  logic             irq,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_mask_wr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_data,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_read;
  logic             r_write;
  logic [1:0]       r_addr;
  logic [31:0]      r_wdata;
  logic [WIDTH-1:0] r_mask;
  logic             r_mask_pend;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_evt_edges;
  logic [WIDTH-1:0] r_evt_data;
  logic             r_evt_valid;
  logic             r_busy;

  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_rd_bits;
  logic             w_unused_rd;
  logic             w_cmd_rd;
  logic             w_cmd_wr;
  logic [1:0]       w_cmd_addr;
  logic [31:0]      w_cmd_wdata;

  assign w_rd_bits   = avm_readdata[WIDTH-1:0];
  assign w_unused_rd = ^avm_readdata;
  assign w_accept    = (r_read | r_write) & ~avm_waitrequest;
  // Command registers only reload when nothing is pending or the pending
  // command is accepted, so they stay frozen through waitrequest stalls.
  assign w_load      = ~(r_read | r_write) | w_accept;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT_MASK: if (w_accept) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (r_mask_pend)  w_state_nxt = S_SET_MASK;
        else if (irq)     w_state_nxt = S_RD_CAP;
      end
      S_SET_MASK:  if (w_accept) w_state_nxt = S_IDLE;
      S_RD_CAP:    if (w_accept) w_state_nxt = S_WAIT_CAP;
      S_WAIT_CAP: begin
        // A zero capture is a spurious irq: nothing to clear or report.
        if (avm_readdatavalid)
          w_state_nxt = (w_rd_bits == '0) ? S_IDLE : S_WR_CLR;
      end
      S_WR_CLR:    if (w_accept) w_state_nxt = S_RD_DATA;
      S_RD_DATA:   if (w_accept) w_state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: if (avm_readdatavalid) w_state_nxt = S_PUSH;
      S_PUSH:      if (evt_ready) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_INIT_MASK;
    endcase
  end

  // Command issued on entry to each bus state. WR_CLR is only entered from
  // WAIT_CAP, so the capture readdata is on the bus in that same cycle.
  always_comb begin
    w_cmd_rd    = 1'b0;
    w_cmd_wr    = 1'b0;
    w_cmd_addr  = ADDR_DATA;
    w_cmd_wdata = '0;
    case (w_state_nxt)
      S_INIT_MASK: begin w_cmd_wr = 1'b1; w_cmd_addr = ADDR_MASK; w_cmd_wdata = 32'(MASK_INIT); end
      S_SET_MASK:  begin w_cmd_wr = 1'b1; w_cmd_addr = ADDR_MASK; w_cmd_wdata = 32'(r_mask);    end
      S_RD_CAP:    begin w_cmd_rd = 1'b1; w_cmd_addr = ADDR_CAP;                                end
      S_WR_CLR:    begin w_cmd_wr = 1'b1; w_cmd_addr = ADDR_CAP;  w_cmd_wdata = 32'(w_rd_bits); end
      S_RD_DATA:   begin w_cmd_rd = 1'b1; w_cmd_addr = ADDR_DATA;                               end
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_INIT_MASK;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mask      <= MASK_INIT;
      r_mask_pend <= 1'b0;
      r_cap       <= '0;
      r_evt_edges <= '0;
      r_evt_data  <= '0;
      r_evt_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_read  <= w_cmd_rd;
        r_write <= w_cmd_wr;
        r_addr  <= w_cmd_addr;
        r_wdata <= w_cmd_wdata;
      end
      if (r_state == S_WAIT_CAP && avm_readdatavalid)
        r_cap <= w_rd_bits;
      if (r_state == S_WAIT_DATA && avm_readdatavalid) begin
        r_evt_edges <= r_cap;
        r_evt_data  <= w_rd_bits;
      end
      r_evt_valid <= (w_state_nxt == S_PUSH);
      r_busy      <= (w_state_nxt != S_IDLE);
      // Pending is only retired when the accepted write carried the current
      // mask; a newer value arriving during the write keeps it pending.
      if (cfg_mask_wr) begin
        r_mask      <= cfg_mask;
        r_mask_pend <= 1'b1;
      end else if (r_state == S_SET_MASK && w_accept && r_wdata[WIDTH-1:0] == r_mask) begin
        r_mask_pend <= 1'b0;
      end
    end
  end

  assign avm_address   = r_addr;
  assign avm_read      = r_read;
  assign avm_write     = r_write;
  assign avm_writedata = r_wdata;
  assign evt_valid     = r_evt_valid;
  assign evt_edges     = r_evt_edges;
  assign evt_data      = r_evt_data;
  assign busy          = r_busy;

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Directed bench for pio_irq_servicer with a behavioural PIO slave model
// (edge capture, IRQ mask, pin data, programmable waitrequest stall).
module tb_pio_irq_servicer;

  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       avm_address;
  logic             avm_read;
  logic             avm_write;
  logic [31:0]      avm_writedata;
  logic [31:0]      avm_readdata = '0;
  logic             avm_readdatavalid = 1'b0;
  logic             avm_waitrequest;
  logic             irq;
  logic [WIDTH-1:0] cfg_mask = '0;
  logic             cfg_mask_wr = 1'b0;
  logic             evt_valid;
  logic             evt_ready = 1'b1;
  logic [WIDTH-1:0] evt_edges;
  logic [WIDTH-1:0] evt_data;
  logic             busy;

  pio_irq_servicer #(.WIDTH(WIDTH), .MASK_INIT(10'h3FF)) dut (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
    .irq(irq), .cfg_mask(cfg_mask), .cfg_mask_wr(cfg_mask_wr),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_edges(evt_edges), .evt_data(evt_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [WIDTH-1:0] sl_cap = '0;
  logic [WIDTH-1:0] sl_mask = '0;
  logic [WIDTH-1:0] sl_pins = '0;
  logic [WIDTH-1:0] inj_cap = '0;
  logic             inj_en = 1'b0;
  logic             irq_ovr = 1'b0;
  int               stall_n = 0;
  int               wcnt = 0;
  int               hold_err = 0;
  int               both_err = 0;
  int               vcnt = 0;
  int               hs = 0;
  logic [1:0]       h_addr = '0;
  logic             h_rd = 1'b0;
  logic             h_wr = 1'b0;
  logic [31:0]      h_wd = '0;
  logic [34:0]      log_q[$];   // {write, address, writedata} per accepted command
  logic [WIDTH-1:0] c_nxt;

  assign irq             = (|(sl_cap & sl_mask)) | irq_ovr;
  assign avm_waitrequest = (avm_read | avm_write) && (wcnt < stall_n);

  always @(posedge clk) begin
    c_nxt = sl_cap;
    avm_readdatavalid <= 1'b0;
    avm_readdata      <= '0;
    if (avm_read && avm_write) both_err <= both_err + 1;
    if (avm_read || avm_write) begin
      if (wcnt != 0 && ({avm_read, avm_write, avm_address, avm_writedata} != {h_rd, h_wr, h_addr, h_wd}))
        hold_err <= hold_err + 1;
      h_rd <= avm_read; h_wr <= avm_write; h_addr <= avm_address; h_wd <= avm_writedata;
      if (wcnt < stall_n) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
        log_q.push_back({avm_write, avm_address, avm_writedata});
        if (avm_read) begin
          avm_readdatavalid <= 1'b1;
          case (avm_address)
            2'd0:    avm_readdata <= 32'(sl_pins);
            2'd2:    avm_readdata <= 32'(sl_mask);
            2'd3:    avm_readdata <= 32'(sl_cap);
            default: avm_readdata <= '0;
          endcase
        end else if (avm_address == 2'd2) begin
          sl_mask <= avm_writedata[WIDTH-1:0];
        end else if (avm_address == 2'd3) begin
          c_nxt = c_nxt & ~avm_writedata[WIDTH-1:0];
        end
      end
    end else begin
      wcnt <= 0;
    end
    if (inj_en) c_nxt = c_nxt | inj_cap;
    sl_cap <= c_nxt;
  end

  always @(posedge clk) begin
    if (evt_valid) vcnt <= vcnt + 1;
    if (evt_valid && evt_ready) hs <= hs + 1;
  end

  // ---------------- helpers ----------------
  task automatic inject(input logic [WIDTH-1:0] v);
    @(negedge clk); inj_cap = v; inj_en = 1'b1;
    @(negedge clk); inj_en = 1'b0;
  endtask

  task automatic wait_evt(input string tag);
    int k;
    k = 0;
    while (!evt_valid && k < 200) begin @(posedge clk); #1; k++; end
    chk({tag, "_evt_seen"}, evt_valid, 1'b1);
  endtask

  task automatic wait_rd(input string tag, input logic [1:0] addr);
    int k;
    k = 0;
    while (!(avm_read && avm_address == addr) && k < 100) begin @(posedge clk); #1; k++; end
    chk({tag, "_rd_seen"}, avm_read, 1'b1);
  endtask

  task automatic chk_cmd(input string tag, input int idx, input logic wr,
                         input logic [1:0] addr, input logic [31:0] data);
    logic [34:0] e;
    if (idx >= log_q.size()) begin
      chk({tag, "_present"}, log_q.size(), idx + 1);
    end else begin
      e = log_q[idx];
      chk({tag, "_kind"}, e[34], wr);
      chk({tag, "_addr"}, e[33:32], addr);
      if (wr) chk({tag, "_wdata"}, e[31:0], data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k, n, unst, hs0, vc;
    logic [WIDTH-1:0] e0, d0;

    // 1: reset and mask programming
    repeat (3) @(posedge clk); #1;
    chk("rst_read", avm_read, 1'b0);
    chk("rst_write", avm_write, 1'b0);
    chk("rst_evt_valid", evt_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk); reset_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("init_count", log_q.size(), 1);
    chk_cmd("init_wr", 0, 1'b1, 2'd2, 32'h3FF);
    chk("init_busy", busy, 1'b0);
    chk("init_slmask", sl_mask, 10'h3FF);

    // 2: basic service and latency
    base = log_q.size();
    sl_pins = 10'h2A5;
    @(negedge clk); inj_cap = 10'h005; inj_en = 1'b1;
    @(posedge clk);
    @(negedge clk); inj_en = 1'b0;
    @(posedge clk); #1;
    chk("lat_rd_cycle1", avm_read, 1'b1);
    chk("lat_rd_addr", avm_address, 2'd3);
    k = 0;
    while (!evt_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk("lat_evt_edges_after_irq", k, 5);
    chk("basic_edges", evt_edges, 10'h005);
    chk("basic_data", evt_data, 10'h2A5);
    repeat (3) @(posedge clk); #1;
    chk("basic_count", log_q.size() - base, 3);
    chk_cmd("basic_rd3", base, 1'b0, 2'd3, 0);
    chk_cmd("basic_wr3", base + 1, 1'b1, 2'd3, 32'h005);
    chk_cmd("basic_rd0", base + 2, 1'b0, 2'd0, 0);
    chk("basic_idle", busy, 1'b0);

    // 3: back-pressure
    evt_ready = 1'b0;
    sl_pins = 10'h111;
    inject(10'h010);
    wait_evt("bp1");
    e0 = evt_edges; d0 = evt_data;
    chk("bp_edges", e0, 10'h010);
    chk("bp_data", d0, 10'h111);
    inject(10'h020);
    n = log_q.size();
    unst = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!evt_valid || evt_edges != e0 || evt_data != d0) unst++;
    end
    chk("bp_stable", unst, 0);
    chk("bp_no_traffic", log_q.size(), n);
    hs0 = hs;
    @(negedge clk); evt_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_single_hs", hs - hs0, 1);
    chk("bp_valid_drop", evt_valid, 1'b0);
    wait_evt("bp2");
    chk("bp_pending_edges", evt_edges, 10'h020);
    repeat (4) @(posedge clk); #1;

    // 4: waitrequest stalls
    stall_n = 3;
    base = log_q.size();
    sl_pins = 10'h3C3;
    inject(10'h100);
    wait_evt("stall");
    chk("stall_edges", evt_edges, 10'h100);
    chk("stall_data", evt_data, 10'h3C3);
    repeat (3) @(posedge clk); #1;
    chk_cmd("stall_rd3", base, 1'b0, 2'd3, 0);
    chk_cmd("stall_wr3", base + 1, 1'b1, 2'd3, 32'h100);
    chk_cmd("stall_rd0", base + 2, 1'b0, 2'd0, 0);
    chk("stall_hold", hold_err, 0);
    stall_n = 0;

    // 5: spurious irq
    base = log_q.size();
    vc = vcnt;
    @(negedge clk); irq_ovr = 1'b1;
    @(negedge clk); irq_ovr = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("spur_count", log_q.size() - base, 1);
    chk_cmd("spur_rd3", base, 1'b0, 2'd3, 0);
    chk("spur_no_evt", vcnt - vc, 0);
    chk("spur_idle", busy, 1'b0);

    // 6a: mask reprogram during WAIT_DATA
    base = log_q.size();
    sl_pins = 10'h0AA;
    inject(10'h002);
    wait_rd("mask", 2'd0);
    @(posedge clk);
    @(negedge clk); cfg_mask = 10'h00F; cfg_mask_wr = 1'b1;
    @(negedge clk); cfg_mask_wr = 1'b0;
    wait_evt("mask");
    chk("mask_edges", evt_edges, 10'h002);
    chk("mask_data", evt_data, 10'h0AA);
    repeat (6) @(posedge clk); #1;
    chk("mask_count", log_q.size() - base, 4);
    chk_cmd("mask_rd3", base, 1'b0, 2'd3, 0);
    chk_cmd("mask_wr3", base + 1, 1'b1, 2'd3, 32'h002);
    chk_cmd("mask_rd0", base + 2, 1'b0, 2'd0, 0);
    chk_cmd("mask_wr2", base + 3, 1'b1, 2'd2, 32'h00F);
    chk("mask_slave", sl_mask, 10'h00F);

    // 6b: reset during a stalled RD_CAP
    stall_n = 3;
    inject(10'h004);
    wait_rd("rstmid", 2'd3);
    n = log_q.size();
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("rstmid_read_drop", avm_read, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    stall_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_evt("rstmid");
    chk("rstmid_edges", evt_edges, 10'h004);
    repeat (4) @(posedge clk); #1;
    chk_cmd("rstmid_init", n, 1'b1, 2'd2, 32'h3FF);
    chk_cmd("rstmid_rd3", n + 1, 1'b0, 2'd3, 0);
    chk_cmd("rstmid_wr3", n + 2, 1'b1, 2'd3, 32'h004);
    chk_cmd("rstmid_rd0", n + 3, 1'b0, 2'd0, 0);

    chk("rw_exclusive", both_err, 0);
    chk("hold_total", hold_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
